// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter over four request lines with a per-grant hold limit.
// Drives the 4:1 mux select directly, plus a one-hot grant and a valid flag.
module rr_mux_select_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] grant_nx;
  logic [1:0] select_nx;
  logic       valid_nx;

  logic [1:0] owner;
  logic [3:0] owner_mask;
  logic [3:0] others;
  logic [1:0] rel_ptr;
  logic [2:0] pick_idle;
  logic [2:0] pick_rel;
  logic       release_nat;
  logic       release_frc;

  // Returns {found, index} of the first set mask bit, searching upward from start (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Owner is whatever select currently encodes; it is only meaningful in GRANT.
  assign owner       = select;
  assign owner_mask  = 4'b0001 << owner;
  assign others      = req & ~owner_mask;
  assign rel_ptr     = owner + 2'd1;
  assign pick_idle   = rr_pick(req, ptr);
  assign pick_rel    = rr_pick(others, rel_ptr);
  assign release_nat = ~req[owner];
  assign release_frc = (MAX_HOLD != 32'd0) && (cnt == 8'(MAX_HOLD)) && (|others);

  // Next-state and next-output logic.
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    cnt_nx    = cnt;
    grant_nx  = grant;
    select_nx = select;
    valid_nx  = valid;
    case (state)
      IDLE: begin
        if (pick_idle[2]) begin
          state_nx  = GRANT;
          grant_nx  = 4'b0001 << pick_idle[1:0];
          select_nx = pick_idle[1:0];
          valid_nx  = 1'b1;
          cnt_nx    = 8'd1;
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT: begin
        if (release_nat || release_frc) begin
          // The released owner is excluded from the same-edge re-arbitration.
          ptr_nx = rel_ptr;
          if (pick_rel[2]) begin
            grant_nx  = 4'b0001 << pick_rel[1:0];
            select_nx = pick_rel[1:0];
            valid_nx  = 1'b1;
            cnt_nx    = 8'd1;
          end else begin
            state_nx = IDLE;
            grant_nx = 4'b0000;
            valid_nx = 1'b0;
          end
        end else if (cnt != 8'd255) begin
          cnt_nx = cnt + 8'd1;
        end else begin
          cnt_nx = cnt;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 4'b0000;
        valid_nx = 1'b0;
      end
    endcase
  end

  // State and registered outputs; select is deliberately not cleared on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      cnt    <= 8'd0;
      grant  <= 4'b0000;
      select <= 2'b00;
      valid  <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      cnt    <= cnt_nx;
      grant  <= grant_nx;
      select <= select_nx;
      valid  <= valid_nx;
    end
  end

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Directed and randomized bench for rr_mux_select_arbiter against a
// behavioural round-robin model kept in plain integers.
module tb_rr_mux_select_arbiter;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       valid;

  int tests;
  int fails;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;

  rr_mux_select_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .select(select),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int start, input int skip);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (start + k) % 4;
      if (r[j] && j != skip) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int w;
    bit rel;
    if (!m_busy) begin
      w = search(r, m_ptr, -1);
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_sel = w; m_cnt = 1;
      end
    end else begin
      rel = !r[m_owner] ||
            (MAXH != 0 && m_cnt == MAXH && (r & ~(4'b0001 << m_owner)) != 4'b0000);
      if (rel) begin
        m_ptr = (m_owner + 1) % 4;
        w = search(r, m_ptr, m_owner);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_cnt = 1;
        end else begin
          m_busy = 1'b0;
        end
      end else if (m_cnt < 255) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    chk({tag, ".grant"},  grant,        eg);
    chk({tag, ".select"}, {2'b00, select}, 4'(m_sel));
    chk({tag, ".valid"},  {3'b000, valid}, {3'b000, m_busy});
  endtask

  // One clock: drive req away from the edge, advance model, sample 1 time unit after.
  task automatic step(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, ".rst_grant"}, grant, 4'b0000);
    chk({tag, ".rst_valid"}, {3'b000, valid}, 4'b0000);
    chk({tag, ".rst_select"}, {2'b00, select}, 4'b0000);
    model_reset();
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    model_reset();

    // Reset held with random requests
    for (int i = 0; i < 4; i++) begin
      req = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      chk("reset_hold.grant", grant, 4'b0000);
      chk("reset_hold.valid", {3'b000, valid}, 4'b0000);
      chk("reset_hold.select", {2'b00, select}, 4'b0000);
    end
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, "reset_release");
    step(4'b0000, "reset_release");

    // Single request, then drop: select holds 10 in idle
    step(4'b0100, "single");
    chk("single.grant_const", grant, 4'b0100);
    step(4'b0100, "single");
    step(4'b0100, "single");
    step(4'b0000, "single_drop");
    chk("single_drop.grant_const", grant, 4'b0000);
    chk("single_drop.select_const", {2'b00, select}, 4'b0010);

    // Full contention from reset: four cycles each, no bubbles
    async_reset("contend");
    for (int i = 0; i < 20; i++) begin
      logic [3:0] eg;
      step(4'b1111, "contend");
      eg = 4'b0001 << ((i / 4) % 4);
      chk("contend.rotation", grant, eg);
    end

    // Natural handover from owner 1 to pending owner 3
    async_reset("handover");
    step(4'b0010, "handover");
    step(4'b1010, "handover");
    step(4'b1010, "handover");
    step(4'b1000, "handover_drop");
    chk("handover.grant_const", grant, 4'b1000);
    chk("handover.select_const", {2'b00, select}, 4'b0011);
    step(4'b0000, "handover_idle");

    // Pointer fairness: after owner 1 releases, index 2 is searched before 0
    async_reset("fair");
    step(4'b0010, "fair");
    step(4'b0000, "fair_idle");
    step(4'b0101, "fair_pick");
    chk("fair.grant_const", grant, 4'b0100);

    // Uncontended hold, then asynchronous reset mid-grant
    async_reset("uncontended");
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, "uncontended");
      chk("uncontended.grant_const", grant, 4'b0001);
    end
    async_reset("midgrant");
    step(4'b0000, "post_reset");

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      if ($urandom_range(0, 3) == 0) r = 4'b1111;
      else r = 4'($urandom_range(0, 15));
      step(r, "random");
      if ($urandom_range(0, 79) == 0) async_reset("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
